rand_range_sampler: RTL and testbench
=====================================

// Module: rand_range_sampler
// PURPOSE
//  Downstream consumer of random_generator's rand_num stream. Draws bytes, maps
//  them uniformly onto 0..range_max by mask-and-reject sampling, and buffers
//  accepted values in a small FIFO behind a valid/ready output. Throttles the
//  generator through its enable input, so no sample is ever dropped on a full FIFO.
// PARAMETERS
//  DATA_W   8   width of rand_num, range_max and out_data
//  DEPTH    4   output FIFO depth (power of 2, >=2)
//  CNT_W    16  width of the reject counter
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  rand_num     in   DATA_W  random_generator output
//  rand_enable  out  1       drives random_generator enable
//  start        in   1       1-cycle pulse: latch range_max/num_req, begin
//  range_max    in   DATA_W  inclusive upper bound of the output range
//  num_req      in   8       number of values to accept in this run
//  out_valid    out  1       FIFO not empty
//  out_data     out  DATA_W  FIFO head
//  out_ready    in   1       consumer pop; transfer when valid && ready
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse at the end of a run
//  reject_cnt   out  CNT_W   saturating count of rejected samples (cleared on start)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; samp_vld=0.
//  States: IDLE -start-> RUN (num_req!=0) or DRAIN (num_req==0).
//    RUN -> DRAIN on the cycle acc_cnt reaches num_req_q. DRAIN -> IDLE when
//    FIFO empty and samp_vld==0; done=1 on that transition. start outside IDLE ignored.
//  Generator latency: rand_num advances on the edge where rand_enable=1, so
//    samp_vld <= rand_enable; rand_num is evaluated only in cycles with samp_vld=1.
//  rand_enable = (state==RUN) && (fifo_count + samp_vld < DEPTH)
//    && (acc_cnt + samp_vld < num_req_q): in-flight samples never overflow the FIFO
//    or exceed the request.
//  Mapping: mask = smallest 2^k-1 >= range_max_q (computed at start, registered);
//    cand = rand_num & mask; accept iff cand <= range_max_q.
//    Accept: push cand, acc_cnt++. Reject: reject_cnt++ (saturates at all-ones).
//  range_max_q==0 -> mask 0; every sample is accepted as 0.
//    range_max_q==255 -> mask 0xFF; no rejects.
//  FIFO: push and pop in the same cycle -> count unchanged, data order kept.
//    Pop on empty impossible (valid=0). out_data is stable while valid && !ready.
//  Runtime changes to range_max/num_req do not affect the run (latched at start).
//  Async reset mid-run: immediate return to reset values; FIFO contents discarded.
// STRUCTURE
//  Package rand_pkg: state enum {IDLE,RUN,DRAIN}; function range_mask(DATA_W);
//    DATA_W default constant.
//  Sub-module rand_fifo (sync FIFO, DEPTH x DATA_W, count output, async rst_n).
//  Top: FSM, mask register, acc/reject counters, enable/samp_vld logic.
// TESTING (stub generator: rand_num steps through a known table when enabled)
//  1 range_max=5, num_req=4, table 0x0D,0x07,0x02,0xFE,0x14,0x03 -> accepts
//    5,2,4,3 (mask 7); reject_cnt=2; done pulses once; busy falls with it.
//  2 range_max=0, num_req=3, out_ready=1 -> out_data 0,0,0; reject_cnt=0.
//  3 range_max=255, num_req=8, out_ready=0 -> rand_enable low once FIFO
//    holds 4 entries; after release all 8 table bytes appear in order, none lost.
//  4 num_req=0 start -> no rand_enable pulse; done within 2 cycles; busy then 0.
//  5 rst_n low mid-RUN with FIFO at 2 entries -> out_valid=0, busy=0,
//    rand_enable=0 immediately; next start runs cleanly.
//  6 start pulsed during RUN with a different range_max -> ignored; outputs
//    stay <= original range_max.

Source files
------------

// File: rtl/rand_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rand_pkg: shared types and helpers for rand_range_sampler            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rand_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Smallest all-ones mask (2^k-1) that covers v.
  function automatic logic [31:0] range_mask(input logic [31:0] v);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (m < v) m = {m[30:0], 1'b1};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rand_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rand_fifo: synchronous DEPTH x DATA_W FIFO with occupancy count      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rand_fifo
  import rand_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full;
  logic              wr_en;
  logic              rd_en;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rand_range_sampler: mask-and-reject mapping of a random byte stream  |
// | onto 0..range_max, buffered behind valid/ready. Rev 1.0              |
// +----------------------------------------------------------------------+
module rand_range_sampler
  import rand_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rand_num,
  output logic              rand_enable,
  input  logic              start,
  input  logic [DATA_W-1:0] range_max,
  input  logic [7:0]        num_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  reject_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] range_max_q, range_max_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [7:0]        num_req_q, num_req_d;
  logic [7:0]        acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  reject_cnt_q, reject_cnt_d;
  logic              samp_vld_q, samp_vld_d;

  logic [DATA_W-1:0] cand;
  logic              accept;
  logic              start_acc;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              pop;

  assign start_acc = start && (state_q == IDLE);
  assign cand      = rand_num & mask_q;
  assign accept    = samp_vld_q && (cand <= range_max_q);
  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign reject_cnt = reject_cnt_q;

  rand_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (cand),
    .pop       (pop),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Datapath: run parameters latched on an accepted start, counters step per sample.
  always_comb begin
    range_max_d  = range_max_q;
    mask_d       = mask_q;
    num_req_d    = num_req_q;
    acc_cnt_d    = acc_cnt_q;
    reject_cnt_d = reject_cnt_q;
    samp_vld_d   = rand_enable;
    if (start_acc) begin
      range_max_d  = range_max;
      mask_d       = DATA_W'(range_mask(32'(range_max)));
      num_req_d    = num_req;
      acc_cnt_d    = '0;
      reject_cnt_d = '0;
    end else if (samp_vld_q) begin
      if (accept) begin
        acc_cnt_d = acc_cnt_q + 8'd1;
      end else if (reject_cnt_q != {CNT_W{1'b1}}) begin
        reject_cnt_d = reject_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_req == 8'd0) ? DRAIN : RUN;
      RUN:     if (acc_cnt_d == num_req_q) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !samp_vld_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counting the in-flight sample keeps both the FIFO and the request from overshooting.
  always_comb begin
    rand_enable = (state_q == RUN)
               && (({1'b0, fifo_count} + (CW+1)'(samp_vld_q)) < (CW+1)'(DEPTH))
               && (({1'b0, acc_cnt_q} + 9'(samp_vld_q)) < {1'b0, num_req_q});
    busy        = (state_q != IDLE);
    done        = (state_q == DRAIN) && fifo_empty && !samp_vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      range_max_q  <= '0;
      mask_q       <= '0;
      num_req_q    <= '0;
      acc_cnt_q    <= '0;
      reject_cnt_q <= '0;
      samp_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      range_max_q  <= range_max_d;
      mask_q       <= mask_d;
      num_req_q    <= num_req_d;
      acc_cnt_q    <= acc_cnt_d;
      reject_cnt_q <= reject_cnt_d;
      samp_vld_q   <= samp_vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rand_range_sampler: scoreboard bench with a table-driven stub     |
// | generator. Rev 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_rand_range_sampler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rand_num;
  logic        rand_enable;
  logic        start = 1'b0;
  logic [7:0]  range_max = '0;
  logic [7:0]  num_req = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] reject_cnt;

  rand_range_sampler #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rand_num    (rand_num),
    .rand_enable (rand_enable),
    .start       (start),
    .range_max   (range_max),
    .num_req     (num_req),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .reject_cnt  (reject_cnt)
  );

  always #5 clk = ~clk;

  // Stub generator: next table byte appears on the edge where enable is high.
  logic [7:0] tbl [64];
  int         ptr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 0;
      rand_num <= 8'h00;
    end else if (rand_enable) begin
      rand_num <= tbl[ptr];
      ptr      <= ptr + 1;
    end
  end

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int en_cnt = 0;

  // Monitor: every transfer is checked against the head of the expectation queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rand_enable) en_cnt++;
      if (rst_n && out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_data: got %h with no value expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_bad++;
            $display("FAIL out_data: got %h, expected %h", out_data, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] rm, input logic [7:0] nr);
    @(posedge clk); #1;
    start = 1'b1; range_max = rm; num_req = nr;
    @(posedge clk); #1;
    start = 1'b0; range_max = ~rm; num_req = 8'd200;
  endtask

  task automatic wait_done(input string name, input int maxc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, " busy with done"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({name, " busy after done"}, 32'(busy), 32'd0);
      chk({name, " done one cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    logic seen;
    for (int i = 0; i < 64; i++) tbl[i] = 8'h5A;
    tbl[0] = 8'h0D; tbl[1] = 8'h07; tbl[2] = 8'h02;
    tbl[3] = 8'hFE; tbl[4] = 8'h14; tbl[5] = 8'h03;
    tbl[6] = 8'hA5; tbl[7] = 8'h3C; tbl[8] = 8'hFF;
    tbl[9]  = 8'h11; tbl[10] = 8'h22; tbl[11] = 8'h33; tbl[12] = 8'h44;
    tbl[13] = 8'h55; tbl[14] = 8'h66; tbl[15] = 8'h77; tbl[16] = 8'h88;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rand_enable", 32'(rand_enable), 32'd0);
    chk("reset reject_cnt", 32'(reject_cnt), 32'd0);

    // 1: range 5, mask 7, two rejects among six draws
    out_ready = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(8'd5); exp_q.push_back(8'd2);
    exp_q.push_back(8'd4); exp_q.push_back(8'd3);
    start_run(8'd5, 8'd4);
    wait_done("t1", 40);
    chk("t1 reject_cnt", 32'(reject_cnt), 32'd2);
    chk("t1 done pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1 queue drained", 32'(exp_q.size()), 32'd0);
    chk("t1 draws", 32'(ptr), 32'd6);

    // 2: range 0, every draw maps to 0
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    start_run(8'd0, 8'd3);
    wait_done("t2", 40);
    chk("t2 reject_cnt", 32'(reject_cnt), 32'd0);
    chk("t2 draws", 32'(ptr), 32'd9);

    // 3: full range with consumer stalled; generator must throttle at 4
    out_ready = 1'b0;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    start_run(8'd255, 8'd8);
    repeat (20) @(negedge clk);
    chk("t3 enable throttled", 32'(rand_enable), 32'd0);
    chk("t3 draws while full", 32'(ptr), 32'd13);
    chk("t3 head held", 32'(out_data), 32'h11);
    chk("t3 busy", 32'(busy), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("t3", 60);
    chk("t3 reject_cnt", 32'(reject_cnt), 32'd0);
    chk("t3 draws", 32'(ptr), 32'd17);
    chk("t3 queue drained", 32'(exp_q.size()), 32'd0);

    // 4: zero-length request
    e0 = en_cnt;
    start_run(8'd9, 8'd0);
    wait_done("t4", 2);
    chk("t4 no enable", 32'(en_cnt - e0), 32'd0);
    chk("t4 draws", 32'(ptr), 32'd17);

    // 5: asynchronous reset with two entries buffered
    out_ready = 1'b0;
    start_run(8'd255, 8'd8);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("t5 fifo filling", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 out_valid in reset", 32'(out_valid), 32'd0);
    chk("t5 busy in reset", 32'(busy), 32'd0);
    chk("t5 enable in reset", 32'(rand_enable), 32'd0);
    chk("t5 reject_cnt in reset", 32'(reject_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(8'd5); exp_q.push_back(8'd2);
    exp_q.push_back(8'd4); exp_q.push_back(8'd3);
    start_run(8'd5, 8'd4);
    wait_done("t5b", 40);
    chk("t5b reject_cnt", 32'(reject_cnt), 32'd2);
    chk("t5b done pulses", 32'(done_cnt - d0), 32'd1);
    chk("t5b queue drained", 32'(exp_q.size()), 32'd0);

    // 6: start during RUN with a narrower range must be ignored
    d0 = done_cnt;
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    exp_q.push_back(8'd3); exp_q.push_back(8'd1);
    start_run(8'd3, 8'd4);
    @(negedge clk);
    chk("t6 busy before restart", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b1; range_max = 8'd0; num_req = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6", 40);
    chk("t6 reject_cnt", 32'(reject_cnt), 32'd0);
    chk("t6 done pulses", 32'(done_cnt - d0), 32'd1);
    chk("t6 queue drained", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
